// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer: byte requests to word memory beats, load extension.
// Optional LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two beats instead of rejecting them.
module lsu_ctrl #(
  parameter int SIZE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [SIZE-1:0] mem_addr,
  output logic            mem_memW,
  output logic [31:0]     mem_dataW,
  output logic [3:0]      mem_wrType,
  input  logic [31:0]     mem_dataR
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [SIZE+1:0] addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     hi_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            fin;
  logic [1:0]      o;
  logic [SIZE-1:0] w;
  logic [3:0]      mask;
  logic [7:0]      mshift;
  logic [63:0]     dshift;
  logic [63:0]     raw64;
  logic [31:0]     raw, ext;
  logic            unused_addr;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]     hi_q;
`endif

  function automatic logic legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // o + n > 4 for the access width encoded in funct3[1:0]
  function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b01:   return off == 2'd3;
      2'b10:   return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  assign unused_addr = ^req_addr[31:SIZE+2];
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

  assign o      = addr_q[1:0];
  assign w      = addr_q[SIZE+1:2];
  assign mask   = (f3_q[1:0] == 2'b00) ? 4'b0001 : (f3_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
  // Upper halves of the shifted mask/data are exactly the second-beat lanes.
  assign mshift = {4'b0000, mask} << o;
  assign dshift = {32'd0, wdata_q} << {o, 3'b000};

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    hi_d       = hi_q;
`else
    hi_d       = 32'd0;
`endif
    rdata_d    = rdata_q;
    err_d      = err_q;
    fin        = 1'b0;
    mem_addr   = '0;
    mem_memW   = 1'b0;
    mem_dataW  = 32'd0;
    mem_wrType = 4'd0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (!legal(req_we, req_funct3)) begin
`else
          if (!legal(req_we, req_funct3) || crosses(req_funct3[1:0], req_addr[1:0])) begin
`endif
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = BEAT0;
            lo_d    = 32'd0;
            hi_d    = 32'd0;
          end
        end
      end
      BEAT0: begin
        mem_addr   = w;
        mem_wrType = mshift[3:0];
        mem_dataW  = dshift[31:0];
        mem_memW   = we_q;
        lo_d       = mem_dataR;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (crosses(f3_q[1:0], o)) begin
          state_d = BEAT1;
        end else begin
          state_d = DONE;
          fin     = 1'b1;
        end
`else
        state_d = DONE;
        fin     = 1'b1;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT1: begin
        mem_addr   = w + SIZE'(1);
        mem_wrType = mshift[7:4];
        mem_dataW  = dshift[63:32];
        mem_memW   = we_q;
        hi_d       = mem_dataR;
        state_d    = DONE;
        fin        = 1'b1;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    raw64 = {hi_d, lo_d} >> {o, 3'b000};
    raw   = raw64[31:0];
    case (f3_q)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'd0, raw[7:0]};
      3'b101:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
    if (fin) begin
      err_d   = 1'b0;
      rdata_d = we_q ? 32'd0 : ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      lo_q    <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      hi_q    <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      hi_q    <= hi_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[SIZE+1:0];
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the core's memory stage and the word-organised data memory (32-bit words, 4-bit byte-lane write enables, combinational read, write on rising clock edge). It accepts one byte-addressed request at a time over a valid/ready handshake. It converts the request to a word address, byte enables and lane-shifted write data, and splits word-crossing accesses into two beats. Load results come back aligned and sign- or zero-extended.

## Interface
- `SIZE`, default 11: word-address width of the data memory; capacity is 2^SIZE words.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and able to accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: request rejected; qualified by `rsp_valid`.
- `mem_addr` out SIZE: word address to memory.
- `mem_memW` out 1: memory write strobe.
- `mem_dataW` out 32: lane-positioned write data.
- `mem_wrType` out 4: byte-lane write enables; bit i enables bits [8i+7:8i].
- `mem_dataR` in 32: memory read data (combinational from `mem_addr`).

## Operation
- States: IDLE, BEAT0, BEAT1, DONE. `req_ready` = (state == IDLE).
- Handshake: a request is accepted when `req_valid && req_ready`; all request fields are registered at acceptance.
- Definitions:
  - o = addr[1:0].
  - n = 1, 2 or 4 bytes.
  - m = 4'b0001, 4'b0011 or 4'b1111.
  - w = addr[SIZE+1:2].
  - Address bits above SIZE+1 are ignored; the address wraps modulo the memory size.
- Crossing access: o + n > 4, i.e. half-word at o = 3, or word at o ≠ 0. Non-crossing accesses with o ≠ 0 (e.g. LH at o = 1) complete in one beat.
- Illegal funct3: any load code other than those listed, or any store code other than 000/001/010. The transition is IDLE → DONE with `rsp_err` = 1 and no memory activity.
- BEAT0:
  - `mem_addr` = w.
  - `mem_wrType` = (m << o)[3:0].
  - `mem_dataW` = wdata << 8·o.
  - `mem_memW` = we.
  - Loads latch `mem_dataR` into lo.
  - Next state: BEAT1 if crossing, else DONE.
- BEAT1:
  - `mem_addr` = (w + 1) mod 2^SIZE, so word 2^SIZE−1 wraps to word 0.
  - `mem_wrType` = m >> (4 − o).
  - `mem_dataW` = wdata >> 8·(4 − o).
  - `mem_memW` = we.
  - Loads latch `mem_dataR` into hi.
  - Next state: DONE.
- DONE:
  - `rsp_valid` = 1.
  - Raw load data = ({hi, lo} >> 8·o)[31:0]; hi = 0 when there was no BEAT1.
  - Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Next state: IDLE.
- Outside BEAT0/BEAT1: `mem_memW` = 0, `mem_wrType` = 0, `mem_addr` = 0, `mem_dataW` = 0.

## Timing
- Reset values: state IDLE; `req_ready` 1; `rsp_valid`, `rsp_err` and `mem_memW` 0; `rsp_rdata`, `mem_addr`, `mem_dataW` and `mem_wrType` 0.
- Latency from acceptance in cycle N:
  - Non-crossing: BEAT0 at N+1, `rsp_valid` at N+2.
  - Crossing: BEAT0 at N+1, BEAT1 at N+2, `rsp_valid` at N+3.
  - Error: `rsp_valid` at N+1.
- Throughput: a new request can be accepted in the cycle after DONE, giving one request per 3 cycles when non-crossing.
- Stores write memory at the end of each BEAT cycle.
- Memory outputs are driven combinationally from the state and registered request; no combinational path from `req_*`.
- `rsp_rdata` and `rsp_err` are registered and hold their value until the next DONE.
- `rst` in any state returns to IDLE on the next edge; no further beats are issued. A crossing store reset after BEAT0 leaves only its first word written, and this is the specified behaviour.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: crossing accesses are split into two beats as described above.
- Undefined: crossing accesses go IDLE → DONE with `rsp_err` = 1, `rsp_rdata` = 0, no memory write, and `rsp_valid` at N+1. BEAT1 logic and the hi register are not built.

## Test plan
- Reset then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → BEAT0 with `mem_addr` 4, `mem_wrType` 1111; LW returns 0xDEADBEEF, `rsp_valid` at N+2.
- SB 0x13 data 0x000000A5 over word 0x11223344, then LB 0x13 and LBU 0x13 → `mem_wrType` 1000, `mem_dataW` 0xA5000000; word becomes 0xA5223344; LB → 0xFFFFFFA5, LBU → 0x000000A5.
- LH at 0x11 on word 0x80FF0000 → single beat, returns 0xFFFFFF00.
- With the macro: SW 0x0E data 0xCAFEBABE over zeroed memory → BEAT0 `mem_addr` 3, `mem_wrType` 1100, data 0xBABE0000; BEAT1 `mem_addr` 4, `mem_wrType` 0011, data 0x0000CAFE; LW 0x0E returns 0xCAFEBABE at N+3.
- Without the macro: the same SW → `rsp_err` 1 at N+1, `mem_memW` never asserted. Illegal load funct3 011 → `rsp_err` 1 in either build.
- Crossing LW at word 2^SIZE−1, offset 2 → BEAT1 `mem_addr` 0. Assert `rst` during BEAT0 of a crossing store → IDLE next cycle, no BEAT1 write, `rsp_valid` never pulses.
